// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared types, constants and clamp helper for the PWM duty sequencer
package pwm_seq_pkg;

    localparam int PW_MAX = 20;
    localparam int PW_W   = 4;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    function automatic int unsigned pw_clamp(input int unsigned value);
        return (value > PW_MAX) ? PW_MAX : value;
    endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// rtl/pwm_seq_table.sv - duty table: clamped synchronous write, asynchronous read
module pwm_seq_table #(
    parameter int DEPTH = pwm_seq_pkg::DEPTH,
    parameter int PW_W  = pwm_seq_pkg::PW_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [PW_W-1:0]  wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [PW_W-1:0]  rd_data
);
    import pwm_seq_pkg::pw_clamp;

    logic [PW_W-1:0] mem [DEPTH];
    logic [PW_W-1:0] wr_clamped;

    assign wr_clamped = PW_W'(pw_clamp(32'(wr_data)));

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_clamped;
        end
    end

    // Combinational read sees pre-edge contents, so a coincident write loads the old value.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - steps PWM pulse_width through a duty table on period boundaries
module pwm_duty_sequencer #(
    parameter int DEPTH   = pwm_seq_pkg::DEPTH,
    parameter int PW_W    = pwm_seq_pkg::PW_W,
    parameter int IDLE_PW = 0,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             period_tick,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [PW_W-1:0]  wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_mode,
    input  logic [3:0]       dwell,
    input  logic [IDX_W-1:0] last_idx,
    output logic [PW_W-1:0]  pulse_width,
    output logic [IDX_W-1:0] step_idx,
    output logic             busy,
    output logic             done
);
    import pwm_seq_pkg::state_t;
    import pwm_seq_pkg::IDLE;
    import pwm_seq_pkg::ARM;
    import pwm_seq_pkg::RUN;

    state_t           state;
    logic             stop_pending;
    logic             loop_lat;
    logic [3:0]       dwell_m1;
    logic [3:0]       dwell_cnt;
    logic [IDX_W-1:0] last_lat;
    logic [IDX_W-1:0] rd_addr;
    logic [PW_W-1:0]  rd_data;
    logic             at_last;
    logic             end_seq;

    pwm_seq_table #(
        .DEPTH (DEPTH),
        .PW_W  (PW_W)
    ) u_table (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    assign at_last = (step_idx == last_lat);
    assign rd_addr = (state == RUN && !at_last) ? step_idx + 1'b1 : '0;

    always_comb begin
        end_seq = 1'b0;
        if (period_tick) begin
            if (state == ARM) begin
                end_seq = stop_pending || stop;
            end else if (state == RUN) begin
                end_seq = stop_pending || stop ||
                          (dwell_cnt == 4'd0 && at_last && !loop_lat);
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            loop_lat     <= 1'b0;
            dwell_m1     <= 4'd0;
            dwell_cnt    <= 4'd0;
            last_lat     <= '0;
            pulse_width  <= PW_W'(IDLE_PW);
            step_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (end_seq) begin
                state        <= IDLE;
                stop_pending <= 1'b0;
                pulse_width  <= PW_W'(IDLE_PW);
                step_idx     <= '0;
                busy         <= 1'b0;
                done         <= 1'b0 | 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            // dwell of 0 wraps to a reload of 15, i.e. 16 periods
                            loop_lat     <= loop_mode;
                            dwell_m1     <= dwell - 4'd1;
                            last_lat     <= last_idx;
                            step_idx     <= '0;
                            stop_pending <= 1'b0;
                            busy         <= 1'b1;
                            state        <= ARM;
                        end
                    end
                    ARM: begin
                        if (period_tick) begin
                            pulse_width <= rd_data;
                            step_idx    <= '0;
                            dwell_cnt   <= dwell_m1;
                            state       <= RUN;
                        end else if (stop) begin
                            stop_pending <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (period_tick) begin
                            if (dwell_cnt != 4'd0) begin
                                dwell_cnt <= dwell_cnt - 4'd1;
                            end else begin
                                step_idx    <= at_last ? '0 : step_idx + 1'b1;
                                pulse_width <= rd_data;
                                dwell_cnt   <= dwell_m1;
                            end
                        end else if (stop) begin
                            stop_pending <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - scoreboard bench for pwm_duty_sequencer
module tb_pwm_duty_sequencer;

    logic       clk_50MHz = 1'b0;
    logic       reset;
    logic       period_tick;
    logic       wr_en, start, stop, loop_mode;
    logic [2:0] wr_addr, last_idx;
    logic [3:0] wr_data, dwell;
    logic [3:0] pulse_width;
    logic [2:0] step_idx;
    logic       busy, done;

    logic       d5_wr_en, d5_start, d5_stop, d5_loop_mode;
    logic [2:0] d5_wr_addr, d5_last_idx;
    logic [4:0] d5_wr_data;
    logic [3:0] d5_dwell;
    logic [4:0] d5_pulse_width;
    logic [2:0] d5_step_idx;
    logic       d5_busy, d5_done;

    typedef struct {
        int   pw;
        logic dn;
        logic bz;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    pwm_duty_sequencer dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .period_tick (period_tick),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .loop_mode   (loop_mode),
        .dwell       (dwell),
        .last_idx    (last_idx),
        .pulse_width (pulse_width),
        .step_idx    (step_idx),
        .busy        (busy),
        .done        (done)
    );

    pwm_duty_sequencer #(.PW_W(5)) dut5 (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .period_tick (period_tick),
        .wr_en       (d5_wr_en),
        .wr_addr     (d5_wr_addr),
        .wr_data     (d5_wr_data),
        .start       (d5_start),
        .stop        (d5_stop),
        .loop_mode   (d5_loop_mode),
        .dwell       (d5_dwell),
        .last_idx    (d5_last_idx),
        .pulse_width (d5_pulse_width),
        .step_idx    (d5_step_idx),
        .busy        (d5_busy),
        .done        (d5_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic wr(input int a, input int d);
        wr_addr = 3'(a);
        wr_data = 4'(d);
        wr_en   = 1'b1;
        @(negedge clk_50MHz);
        wr_en   = 1'b0;
    endtask

    task automatic go(input int dw, input int li, input logic lp);
        dwell     = 4'(dw);
        last_idx  = 3'(li);
        loop_mode = lp;
        start     = 1'b1;
        @(negedge clk_50MHz);
        start     = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk_50MHz);
        stop = 1'b0;
    endtask

    task automatic tick(input string tag, input int pw, input logic dn, input logic bz,
                        input logic with_stop);
        exp_t e;
        exp_t got;
        cycles(2);
        e.pw = pw;
        e.dn = dn;
        e.bz = bz;
        exp_q.push_back(e);
        period_tick = 1'b1;
        stop        = with_stop;
        @(negedge clk_50MHz);
        period_tick = 1'b0;
        stop        = 1'b0;
        got = exp_q.pop_front();
        chk({tag, ".pw"},   32'(pulse_width), 32'(got.pw));
        chk({tag, ".done"}, 32'(done),        32'(got.dn));
        chk({tag, ".busy"}, 32'(busy),        32'(got.bz));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; period_tick = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0; dwell = '0; last_idx = '0;
        d5_wr_en = 1'b0; d5_wr_addr = '0; d5_wr_data = '0;
        d5_start = 1'b0; d5_stop = 1'b0; d5_loop_mode = 1'b0; d5_dwell = '0; d5_last_idx = '0;
        cycles(2);
        chk("rst.pw",   32'(pulse_width), 32'd0);
        chk("rst.busy", 32'(busy),        32'd0);
        chk("rst.done", 32'(done),        32'd0);
        chk("rst.idx",  32'(step_idx),    32'd0);
        reset = 1'b0;
        cycles(1);

        wr(0, 8); wr(1, 11); wr(2, 4); wr(3, 12);
        go(1, 3, 1'b0);
        chk("os.busy_rise", 32'(busy), 32'd1);
        tick("os1", 8, 1'b0, 1'b1, 1'b0);
        chk("os1.idx", 32'(step_idx), 32'd0);
        tick("os2", 11, 1'b0, 1'b1, 1'b0);
        cycles(3);
        chk("os2.hold", 32'(pulse_width), 32'd11);
        chk("os2.idx",  32'(step_idx),    32'd1);
        tick("os3", 4, 1'b0, 1'b1, 1'b0);
        tick("os4", 12, 1'b0, 1'b1, 1'b0);
        chk("os4.idx", 32'(step_idx), 32'd3);
        tick("os5", 0, 1'b1, 1'b0, 1'b0);
        cycles(1);
        chk("os5.done_fall", 32'(done), 32'd0);
        tick("os6_idle", 0, 1'b0, 1'b0, 1'b0);

        go(1, 3, 1'b0);
        tick("sw1", 8, 1'b0, 1'b1, 1'b0);
        cycles(2);
        wr_addr = 3'd1; wr_data = 4'd9; wr_en = 1'b1; period_tick = 1'b1;
        @(negedge clk_50MHz);
        wr_en = 1'b0; period_tick = 1'b0;
        chk("sw2.old_value", 32'(pulse_width), 32'd11);
        tick("sw3", 4, 1'b0, 1'b1, 1'b0);
        tick("sw4", 12, 1'b0, 1'b1, 1'b0);
        tick("sw5", 0, 1'b1, 1'b0, 1'b0);
        go(1, 3, 1'b0);
        tick("sw6", 8, 1'b0, 1'b1, 1'b0);
        tick("sw7_new_value", 9, 1'b0, 1'b1, 1'b0);
        stop_pulse();
        cycles(3);
        chk("sw7.stop_hold", 32'(pulse_width), 32'd9);
        tick("sw8_stop", 0, 1'b1, 1'b0, 1'b0);

        wr(0, 4); wr(1, 5);
        go(2, 1, 1'b1);
        tick("lp1", 4, 1'b0, 1'b1, 1'b0);
        tick("lp2", 4, 1'b0, 1'b1, 1'b0);
        tick("lp3", 5, 1'b0, 1'b1, 1'b0);
        tick("lp4", 5, 1'b0, 1'b1, 1'b0);
        tick("lp5", 4, 1'b0, 1'b1, 1'b0);
        tick("lp6", 4, 1'b0, 1'b1, 1'b0);
        tick("lp7", 5, 1'b0, 1'b1, 1'b0);
        go(1, 0, 1'b0);
        tick("lp8_start_ignored", 5, 1'b0, 1'b1, 1'b0);
        stop_pulse();
        cycles(3);
        chk("lp.stop_hold_pw",   32'(pulse_width), 32'd5);
        chk("lp.stop_hold_busy", 32'(busy),        32'd1);
        tick("lp9_stop", 0, 1'b1, 1'b0, 1'b0);
        cycles(1);
        chk("lp9.done_fall", 32'(done), 32'd0);

        dwell = 4'd2; last_idx = 3'd1; loop_mode = 1'b1;
        start = 1'b1; stop = 1'b1;
        @(negedge clk_50MHz);
        start = 1'b0; stop = 1'b0;
        chk("ss.start_wins", 32'(busy), 32'd1);
        tick("ss1", 4, 1'b0, 1'b1, 1'b0);
        tick("ss2_coincident_stop", 0, 1'b1, 1'b0, 1'b1);

        go(1, 3, 1'b0);
        stop_pulse();
        tick("arm_stop", 0, 1'b1, 1'b0, 1'b0);

        wr(0, 13); wr(1, 15);
        go(0, 1, 1'b0);
        for (int i = 0; i < 16; i++) tick("dw0_e0", 13, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick("dw0_e1", 15, 1'b0, 1'b1, 1'b0);
        tick("dw0_end", 0, 1'b1, 1'b0, 1'b0);

        d5_wr_addr = 3'd0; d5_wr_data = 5'd25; d5_wr_en = 1'b1;
        @(negedge clk_50MHz);
        d5_wr_en = 1'b0;
        d5_dwell = 4'd1; d5_last_idx = 3'd0; d5_loop_mode = 1'b0; d5_start = 1'b1;
        @(negedge clk_50MHz);
        d5_start = 1'b0;
        tick("cl_main_idle", 0, 1'b0, 1'b0, 1'b0);
        chk("cl.clamped", 32'(d5_pulse_width), 32'd20);
        tick("cl_main_idle2", 0, 1'b0, 1'b0, 1'b0);
        chk("cl.end_pw",   32'(d5_pulse_width), 32'd0);
        chk("cl.end_done", 32'(d5_done),        32'd1);

        wr(0, 4); wr(1, 5);
        go(2, 1, 1'b1);
        tick("rr1", 4, 1'b0, 1'b1, 1'b0);
        @(posedge clk_50MHz);
        #5 reset = 1'b1;
        #1;
        chk("rr.pw",   32'(pulse_width), 32'd0);
        chk("rr.busy", 32'(busy),        32'd0);
        chk("rr.done", 32'(done),        32'd0);
        @(negedge clk_50MHz);
        reset = 1'b0;
        go(1, 1, 1'b0);
        tick("rr_tbl0", 0, 1'b0, 1'b1, 1'b0);
        tick("rr_tbl1", 0, 1'b0, 1'b1, 1'b0);
        tick("rr_end", 0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Sequencing controller for the 50 MHz PWM generator (1 MHz / 500 Hz prescaler, 4-bit `pulse_width`, 2 ms period of 20 × 100 µs steps). Holds a small table of duty values and drives the generator's `pulse_width` input, stepping through the table after a programmable number of PWM periods. Updates happen only at period boundaries, so no PWM period ever sees a mid-period duty change. Supports one-shot and looping playback, plus a graceful stop.

## Interface
- `DEPTH`, 8: number of table entries (power of two).
- `PW_W`, 4: width of a `pulse_width` value.
- `IDLE_PW`, 0: `pulse_width` driven while not running.

- `clk_50MHz`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `period_tick`  in  1  one-cycle pulse from the PWM generator at the start of each 2 ms period.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  log2(DEPTH)  table write address.
- `wr_data`  in  PW_W  table write data; values 0–20 are legal, values above 20 are clamped to 20 on write.
- `start`  in  1  one-cycle start request.
- `stop`  in  1  one-cycle graceful stop request.
- `loop_mode`  in  1  1 = wrap to entry 0 after the last entry; sampled on `start`.
- `dwell`  in  4  periods per entry; sampled on `start`; 0 means 16.
- `last_idx`  in  log2(DEPTH)  index of the final entry; sampled on `start`.
- `pulse_width`  out  PW_W  duty value to the PWM generator.
- `step_idx`  out  log2(DEPTH)  index of the entry currently driven.
- `busy`  out  1  high in ARM and RUN.
- `done`  out  1  one-cycle pulse when the block returns to IDLE from ARM or RUN.

## Operation
- Reset values:
  - state IDLE
  - `pulse_width` = IDLE_PW
  - `step_idx` = 0, `busy` = 0, `done` = 0
  - stop_pending = 0
  - table contents all 0
- Table writes:
  - Accepted in every state.
  - Read-before-write: if a write hits the entry being loaded on the same cycle, the old value is loaded.
- **IDLE**:
  - On `start`: latch `loop_mode`, `dwell` (0 becomes 16) and `last_idx`; set idx = 0; go to ARM.
  - `stop` is ignored in IDLE.
- **ARM**:
  - Waits for the first `period_tick`.
  - On the tick: `pulse_width` = table[0], `step_idx` = 0, dwell_cnt = dwell−1; go to RUN.
- **RUN**, on `period_tick`, first matching rule wins:
  1. stop_pending set → IDLE; `pulse_width` = IDLE_PW; `done` pulses.
  2. dwell_cnt ≠ 0 → decrement dwell_cnt.
  3. idx = last_idx and loop_mode = 0 → IDLE; `pulse_width` = IDLE_PW; `done` pulses.
  4. idx = last_idx and loop_mode = 1 → idx = 0; load table[0]; reload dwell_cnt.
  5. Otherwise → idx + 1; load table[idx+1]; reload dwell_cnt.
- **Stop handling**:
  - `stop` in ARM or RUN sets stop_pending; it is cleared on entering IDLE.
  - `stop` and `period_tick` on the same cycle in RUN end the sequence on that tick.
  - Stop in ARM takes effect at the next tick: ARM → IDLE, `done` pulses, table[0] is never driven.
- `start` while `busy` is ignored.
- `start` and `stop` on the same cycle in IDLE: start is taken; stop is ignored.
- A `period_tick` that arrives in IDLE has no effect.
- Reset asserted mid-sequence returns all state to reset values immediately; the table is also cleared.

## Timing
- All outputs are registered.
- State and outputs update on the same `clk_50MHz` edge that samples `period_tick` (or `start`). New values are valid from the following cycle.
- The PWM generator latches `pulse_width` one cycle after its own `period_tick`.
- Start-to-ARM latency: 1 cycle (`busy` rises the cycle after `start`).
- `done` is high for exactly one cycle, coincident with the first IDLE cycle.
- Each entry is driven for exactly `dwell` full PWM periods (2 ms × dwell).
- One-shot sequence length: (last_idx+1) × dwell periods.

## Structure
- Package `pwm_seq_pkg` holds:
  - state enum {IDLE, ARM, RUN}
  - PW_MAX = 20
  - PW_W and the index-width localparams
  - the clamp function
- Sub-module `pwm_seq_table`: DEPTH × PW_W register file. Synchronous write, asynchronous read, clamp applied on write, cleared by `reset`.
- The top level holds the FSM, dwell counter, index counter and output registers.

## Test plan
- **One-shot:**
  - Stimulus: write table {8,11,4,12}, `dwell` = 1, `last_idx` = 3, `loop_mode` = 0, start, 6 ticks.
  - Required: `pulse_width` 8,11,4,12 on successive periods, then 0; `done` pulses once on the 5th tick.
- **Loop with dwell:**
  - Stimulus: table {4,5}, `dwell` = 2, `last_idx` = 1, `loop_mode` = 1.
  - Required: sequence 4,4,5,5,4,4…; `busy` stays 1.
- **Stop mid-period:**
  - Stimulus: running the loop above, `stop` asserted between ticks while driving 5.
  - Required: 5 holds until the next tick, then 0 and `done`; a `stop` coincident with a tick ends on that tick.
- **Clamp and dwell = 0:**
  - Stimulus: write 13, then 15 (above 20 is impossible in 4 bits, so also check the clamp path with `PW_W` = 5 and `wr_data` = 25); set `dwell` = 0.
  - Required: 25 reads back as 20; each entry lasts 16 periods.
- **Same-cycle write:**
  - Stimulus: write entry 1 = 9 on the same cycle the tick loads entry 1 (old value 11).
  - Required: 11 is driven; 9 is driven on the next visit.
- **Reset mid-RUN:**
  - Stimulus: assert `reset` asynchronously between clock edges during RUN.
  - Required: `pulse_width` = 0, `busy` = 0, `done` = 0 immediately; table reads 0.
